// File: rtl/rv_fdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_fdu_pkg
// Description : Shared opcode/funct3 constants, ALU op encoding, decode result
//               struct and the instruction decode function for the RV
//               fetch/decode front end.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_fdu_pkg;

    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;

    localparam logic [2:0] F3_ADD_SUB  = 3'b000;
    localparam logic [2:0] F3_SLL      = 3'b001;
    localparam logic [2:0] F3_SLT      = 3'b010;
    localparam logic [2:0] F3_SLTU     = 3'b011;
    localparam logic [2:0] F3_XOR      = 3'b100;
    localparam logic [2:0] F3_SR       = 3'b101;
    localparam logic [2:0] F3_OR       = 3'b110;
    localparam logic [2:0] F3_AND      = 3'b111;

    localparam logic [6:0] F7_BASE     = 7'b0000000;
    localparam logic [6:0] F7_ALT      = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_OR   = 4'd2,
        ALU_AND  = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    typedef struct packed {
        logic        legal;
        logic        use_imm;   // operand 2 comes from imm instead of rs2
        alu_op_e     op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [11:0] imm;       // sign-extended by the consumer; shamt already zero-padded
    } decode_t;

    // Map funct3 plus the alternate bit (instr[30]) onto an ALU op.
    function automatic alu_op_e f3_to_op(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        op = ALU_ADD;
        case (f3)
            F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:     op = ALU_SLL;
            F3_SLT:     op = ALU_SLT;
            F3_SLTU:    op = ALU_SLTU;
            F3_XOR:     op = ALU_XOR;
            F3_SR:      op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:      op = ALU_OR;
            default:    op = ALU_AND;
        endcase
        return op;
    endfunction

    // Decode an R-type or OP-IMM word; anything else comes back with legal = 0.
    function automatic decode_t decode(input logic [31:0] instr, input logic rv64);
        decode_t    d;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [5:0] f6;
        logic [11:0] shamt;
        f3    = instr[14:12];
        f7    = instr[31:25];
        f6    = instr[31:26];
        shamt = rv64 ? {6'b0, instr[25:20]} : {7'b0, instr[24:20]};
        d         = '0;
        d.rd      = instr[11:7];
        d.rs1     = instr[19:15];
        d.rs2     = instr[24:20];
        d.op      = ALU_ADD;
        case (instr[6:0])
            OPC_OP: begin
                d.legal = (f7 == F7_BASE) ||
                          ((f7 == F7_ALT) && ((f3 == F3_ADD_SUB) || (f3 == F3_SR)));
                d.op    = f3_to_op(f3, f7[5]);
            end
            OPC_OP_IMM: begin
                d.use_imm = 1'b1;
                d.imm     = instr[31:20];
                if (f3 == F3_SLL) begin
                    d.legal = rv64 ? (f6 == 6'b0) : (f7 == F7_BASE);
                    d.imm   = shamt;
                    d.op    = ALU_SLL;
                end else if (f3 == F3_SR) begin
                    d.legal = rv64 ? ((f6 == 6'b0) || (f6 == 6'b010000))
                                   : ((f7 == F7_BASE) || (f7 == F7_ALT));
                    d.imm   = shamt;
                    d.op    = f3_to_op(f3, instr[30]);
                end else begin
                    // ADDI has no subtract form, so the alternate bit is ignored.
                    d.legal = 1'b1;
                    d.op    = f3_to_op(f3, 1'b0);
                end
            end
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv_fdu_ibuf.sv
`default_nettype none
// ============================================================================
// Module      : rv_fdu_ibuf
// Description : Synchronous FIFO used as the prefetch instruction buffer.
//               Push when full and pop when empty are ignored; flush empties.
// Revision    : 1.0 - initial release
// ============================================================================
module rv_fdu_ibuf #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q,  count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Pointer and occupancy next-state; depth is a power of 2 so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

    // Pointer/count registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are only meaningful while counted, so no reset.
    always_ff @(posedge clk_i) begin
        if (push_ok && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule
`default_nettype wire

// File: rtl/rv_fetch_decode_q.sv
`default_nettype none
// ============================================================================
// Module      : rv_fetch_decode_q
// Description : Pipelined fetch/decode front end: credit-limited fetch
//               requests, prefetch buffer, ALU-op decode, registered issue
//               stage with backpressure and redirect with stale-fetch drop.
// Revision    : 1.0 - initial release
// ============================================================================
module rv_fetch_decode_q
    import rv_fdu_pkg::*;
#(
    parameter int               XLEN        = 32,
    parameter logic [XLEN-1:0]  PC_RESET    = XLEN'('h0001_0000),
    parameter int               FETCH_DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    output logic             fetch_valid_o,
    input  logic             fetch_rdy_i,
    output logic [XLEN-1:0]  fetch_addr_o,
    input  logic             instr_word_valid_i,
    input  logic [31:0]      instruction_word_i,
    output logic [4:0]       rf_rd_addr1_o,
    output logic [4:0]       rf_rd_addr2_o,
    input  logic [XLEN-1:0]  rf_rd_data1_i,
    input  logic [XLEN-1:0]  rf_rd_data2_i,
    input  logic             redirect_valid_i,
    input  logic [XLEN-1:0]  redirect_pc_i,
    output logic             alu_op_valid_o,
    input  logic             alu_rdy_i,
    output logic [3:0]       alu_op_o,
    output logic [XLEN-1:0]  alu_in1_o,
    output logic [XLEN-1:0]  alu_in2_o,
    output logic [4:0]       alu_addr_o,
    output logic             alu_reg_mem_n_o,
    output logic             illegal_instr_o
);

    localparam int CW = $clog2(FETCH_DEPTH) + 1;

    logic [XLEN-1:0] pc_q,        pc_d;
    logic [CW-1:0]   outst_q,     outst_d;
    logic [CW-1:0]   drop_q,      drop_d;
    logic            valid_q,     valid_d;
    alu_op_e         op_q,        op_d;
    logic [XLEN-1:0] in1_q,       in1_d;
    logic [XLEN-1:0] in2_q,       in2_d;
    logic [4:0]      rd_q,        rd_d;
    logic            regw_q,      regw_d;
    logic            illegal_q,   illegal_d;

    logic [31:0]     head_word;
    logic            buf_full;
    logic            buf_empty;
    logic [CW-1:0]   buf_count;
    logic            accept;
    logic            resp;
    logic            push;
    logic            issue_en;
    decode_t         dec;
    logic [XLEN-1:0] imm_ext;

    // Credits cover both requests in flight and words already buffered,
    // so the buffer can never overflow.
    assign fetch_valid_o = !reset_i &&
                           (({1'b0, outst_q} + {1'b0, buf_count}) < (CW+1)'(FETCH_DEPTH));
    assign fetch_addr_o  = pc_q;
    assign accept        = fetch_valid_o && fetch_rdy_i;
    // Responses with nothing outstanding (e.g. left over from before reset) are ignored.
    assign resp          = instr_word_valid_i && (outst_q != '0);
    assign push          = resp && (drop_q == '0) && !redirect_valid_i;
    assign issue_en      = !buf_empty && (!valid_q || alu_rdy_i) && !redirect_valid_i;

    rv_fdu_ibuf #(
        .DEPTH (FETCH_DEPTH),
        .WIDTH (32)
    ) u_ibuf (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .flush_i (redirect_valid_i),
        .push_i  (push),
        .data_i  (instruction_word_i),
        .pop_i   (issue_en),
        .data_o  (head_word),
        .full_o  (buf_full),
        .empty_o (buf_empty),
        .count_o (buf_count)
    );

    assign dec           = decode(head_word, (XLEN == 64));
    assign imm_ext       = {{(XLEN-12){dec.imm[11]}}, dec.imm};
    assign rf_rd_addr1_o = buf_empty ? 5'd0 : dec.rs1;
    assign rf_rd_addr2_o = buf_empty ? 5'd0 : dec.rs2;

    // Next-state for PC, credit/drop counters and the issue register.
    always_comb begin
        pc_d      = pc_q;
        outst_d   = outst_q + CW'(accept) - CW'(resp);
        drop_d    = drop_q;
        valid_d   = valid_q;
        op_d      = op_q;
        in1_d     = in1_q;
        in2_d     = in2_q;
        rd_d      = rd_q;
        regw_d    = regw_q;
        illegal_d = 1'b0;

        if (redirect_valid_i) begin
            pc_d    = redirect_pc_i;
            // Every request still in flight after this cycle belongs to the old path.
            drop_d  = outst_d;
            valid_d = 1'b0;
        end else begin
            if (accept) pc_d = pc_q + XLEN'(4);
            if (resp && (drop_q != '0)) drop_d = drop_q - 1'b1;
            if (issue_en) begin
                valid_d   = dec.legal;
                illegal_d = !dec.legal;
                if (dec.legal) begin
                    op_d   = dec.op;
                    in1_d  = rf_rd_data1_i;
                    in2_d  = dec.use_imm ? imm_ext : rf_rd_data2_i;
                    rd_d   = dec.rd;
                    regw_d = 1'b1;
                end
            end else if (alu_rdy_i) begin
                valid_d = 1'b0;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pc_q      <= PC_RESET;
            outst_q   <= '0;
            drop_q    <= '0;
            valid_q   <= 1'b0;
            op_q      <= ALU_ADD;
            in1_q     <= '0;
            in2_q     <= '0;
            rd_q      <= '0;
            regw_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            outst_q   <= outst_d;
            drop_q    <= drop_d;
            valid_q   <= valid_d;
            op_q      <= op_d;
            in1_q     <= in1_d;
            in2_q     <= in2_d;
            rd_q      <= rd_d;
            regw_q    <= regw_d;
            illegal_q <= illegal_d;
        end
    end

    // A response must always match an outstanding request.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(instr_word_valid_i && (outst_q == '0)));
        end
    end

    assign alu_op_valid_o  = valid_q;
    assign alu_op_o        = op_q;
    assign alu_in1_o       = in1_q;
    assign alu_in2_o       = in2_q;
    assign alu_addr_o      = rd_q;
    assign alu_reg_mem_n_o = regw_q;
    assign illegal_instr_o = illegal_q;

    logic unused_ok;
    assign unused_ok = buf_full;

endmodule
`default_nettype wire
